// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the combinational
// instruction memory and buffers {pc, instr} pairs in a prefetch queue toward decode.
module imem_fetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pcplus4,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    ERR  = 2'b10
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [31:0]   fetch_pc_r;
  logic [AW:0]   count_r;
  logic [AW-1:0] wptr_r, rptr_r;
  logic [31:0]   q_pc_r    [DEPTH];
  logic [31:0]   q_instr_r [DEPTH];
  logic          misalign_r;
  logic          redir_s, misalign_s, pop_s, push_s, empty_s;

  // Redirects are ignored once in ERR so the error state stays frozen until reset.
  assign redir_s    = redirect_valid & (state_r != ERR);
  assign misalign_s = redir_s & (redirect_pc[1:0] != 2'b00);
  assign empty_s    = (count_r == '0);
  assign out_valid  = ~empty_s & ~redirect_valid;
  assign pop_s      = out_valid & out_ready;
  assign push_s     = (state_r == RUN) & fetch_en & ~redirect_valid & ((count_r < DEPTH_C) | pop_s);
  assign imem_addr  = fetch_pc_r;
  assign misalign_err = misalign_r;

  // Head-of-queue view, forced to zero when empty.
  always_comb begin
    out_pc      = 32'h0000_0000;
    out_instr   = 32'h0000_0000;
    out_pcplus4 = 32'h0000_0000;
    if (!empty_s) begin
      out_pc      = q_pc_r[rptr_r];
      out_instr   = q_instr_r[rptr_r];
      out_pcplus4 = q_pc_r[rptr_r] + 32'd4;
    end else begin
      out_pc      = 32'h0000_0000;
    end
  end

  // Next-state logic; misaligned redirect wins from any non-error state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (misalign_s)    state_nxt_s = ERR;
        else if (fetch_en) state_nxt_s = RUN;
        else               state_nxt_s = IDLE;
      end
      RUN: begin
        if (misalign_s)     state_nxt_s = ERR;
        else if (!fetch_en) state_nxt_s = IDLE;
        else                state_nxt_s = RUN;
      end
      ERR:     state_nxt_s = ERR;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, PC, pointers, occupancy and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      count_r    <= '0;
      wptr_r     <= '0;
      rptr_r     <= '0;
      misalign_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (misalign_s) misalign_r <= 1'b1;
      else            misalign_r <= misalign_r;
      if (redir_s) begin
        fetch_pc_r <= {redirect_pc[31:2], 2'b00};
        count_r    <= '0;
        wptr_r     <= '0;
        rptr_r     <= '0;
      end else begin
        if (push_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
          wptr_r     <= wptr_r + AW'(1);
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end
        if (pop_s) rptr_r <= rptr_r + AW'(1);
        else       rptr_r <= rptr_r;
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + (AW+1)'(1);
          2'b01:   count_r <= count_r - (AW+1)'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Queue storage; the captured word is the one imem returns for fetch_pc this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_r[i]    <= 32'h0000_0000;
        q_instr_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      q_pc_r[wptr_r]    <= fetch_pc_r;
      q_instr_r[wptr_r] <= imem_rd;
    end else begin
      q_pc_r[wptr_r]    <= q_pc_r[wptr_r];
    end
  end

endmodule
